// File: rtl/ucsbece154b_branch_resolve_pkg.sv
// ucsbece154b_branch_resolve_pkg: opcode defines shared with the branch predictor,
// control-flow classification and statistics constants.
package ucsbece154b_branch_resolve_pkg;

    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;

    localparam logic [31:0] STAT_MAX = 32'hFFFF_FFFF;

    typedef enum logic [1:0] {
        CF_NONE,
        CF_BRANCH,
        CF_JUMP
    } cf_kind_t;

    function automatic cf_kind_t decode_cf(input logic [6:0] op);
        return (op == OP_BRANCH) ? CF_BRANCH :
               (op == OP_JAL || op == OP_JALR) ? CF_JUMP : CF_NONE;
    endfunction

endpackage

// File: rtl/ucsbece154b_pred_pipe_reg.sv
// ucsbece154b_pred_pipe_reg: one prediction pipeline slot (valid + payload).
// Flush wins over stall; a flushed slot also zeroes its payload.
module ucsbece154b_pred_pipe_reg #(
    parameter int W = 70
) (
    input  logic         clk,
    input  logic         reset_i,
    input  logic         stall,
    input  logic         flush,
    input  logic         next_valid,
    input  logic [W-1:0] next_data,
    output logic         valid,
    output logic [W-1:0] data
);

    always_ff @(posedge clk or negedge reset_i) begin
        if (!reset_i) begin
            valid <= 1'b0;
            data  <= '0;
        end else if (flush) begin
            valid <= 1'b0;
            data  <= '0;
        end else if (!stall) begin
            valid <= next_valid;
            data  <= next_data;
        end
    end

endmodule

// File: rtl/ucsbece154b_branch_resolve.sv
// ucsbece154b_branch_resolve: carries fetch predictions to E and resolves them.
// Optional BRANCH_STATS_EN adds saturating branch / mispredict counters.
module ucsbece154b_branch_resolve
    import ucsbece154b_branch_resolve_pkg::*;
#(
    parameter int NUM_BTB_ENTRIES = 8,
    parameter int NUM_GHR_BITS    = 5
) (
    input  logic                               clk,
    input  logic                               reset_i,
    input  logic                               StallD_i,
    input  logic                               FlushD_i,
    input  logic                               FlushE_i,
    input  logic [31:0]                        PCF_i,
    input  logic                               BranchTakenF_i,
    input  logic [31:0]                        BTBtargetF_i,
    input  logic [NUM_GHR_BITS-1:0]            PHTreadaddressF_i,
    input  logic [6:0]                         opE_i,
    input  logic                               BranchCondE_i,
    input  logic [31:0]                        PCTargetE_i,
    output logic                               MispredictE_o,
    output logic [31:0]                        PCRedirectE_o,
    output logic                               BTB_we_o,
    output logic [$clog2(NUM_BTB_ENTRIES)-1:0] BTBwriteaddress_o,
    output logic [31:0]                        BTBwritedata_o,
    output logic [31:0]                        PCE_o,
    output logic                               PHTwe_o,
    output logic                               PHTincrement_o,
    output logic [NUM_GHR_BITS-1:0]            PHTwriteaddress_o,
    output logic                               GHRreset_o
`ifdef BRANCH_STATS_EN
    ,
    output logic [31:0]                        BranchCountE_o,
    output logic [31:0]                        MispredictCountE_o
`endif
);

    localparam int BTB_W  = $clog2(NUM_BTB_ENTRIES);
    localparam int SLOT_W = 32 + 1 + 32 + NUM_GHR_BITS;

    logic              d_valid, e_valid;
    logic [SLOT_W-1:0] d_data, e_data;
    logic [31:0]       pce, pred_target;
    logic              pred_taken, actual_taken;
    logic [NUM_GHR_BITS-1:0] pht_idx;
    cf_kind_t          cf;

    ucsbece154b_pred_pipe_reg #(.W(SLOT_W)) u_fd (
        .clk        (clk),
        .reset_i    (reset_i),
        .stall      (StallD_i),
        .flush      (FlushD_i),
        .next_valid (1'b1),
        .next_data  ({PCF_i, BranchTakenF_i, BTBtargetF_i, PHTreadaddressF_i}),
        .valid      (d_valid),
        .data       (d_data)
    );

    ucsbece154b_pred_pipe_reg #(.W(SLOT_W)) u_de (
        .clk        (clk),
        .reset_i    (reset_i),
        .stall      (1'b0),
        .flush      (FlushE_i),
        .next_valid (d_valid),
        .next_data  (d_data),
        .valid      (e_valid),
        .data       (e_data)
    );

    assign {pce, pred_taken, pred_target, pht_idx} = e_data;

    // Gating actual-taken by valid keeps an empty E slot redirecting to PCE+4.
    always_comb begin
        cf            = decode_cf(opE_i);
        actual_taken  = e_valid && (cf == CF_JUMP || (cf == CF_BRANCH && BranchCondE_i));
        MispredictE_o = e_valid && ((pred_taken != actual_taken) ||
                                    (actual_taken && pred_target != PCTargetE_i));
        PCRedirectE_o = actual_taken ? PCTargetE_i : pce + 32'd4;
    end

    assign PCE_o             = pce;
    assign BTB_we_o          = MispredictE_o && actual_taken && cf != CF_NONE;
    assign BTBwriteaddress_o = pce[BTB_W+1:2];
    assign BTBwritedata_o    = PCTargetE_i;
    assign PHTwe_o           = e_valid && cf == CF_BRANCH;
    assign PHTincrement_o    = actual_taken;
    assign PHTwriteaddress_o = pht_idx;
    assign GHRreset_o        = MispredictE_o;

`ifdef BRANCH_STATS_EN
    always_ff @(posedge clk or negedge reset_i) begin
        if (!reset_i) begin
            BranchCountE_o     <= '0;
            MispredictCountE_o <= '0;
        end else begin
            if (e_valid && cf != CF_NONE && BranchCountE_o != STAT_MAX)
                BranchCountE_o <= BranchCountE_o + 32'd1;
            if (MispredictE_o && MispredictCountE_o != STAT_MAX)
                MispredictCountE_o <= MispredictCountE_o + 32'd1;
        end
    end
`endif

endmodule
